// File: rtl/ifu_prefetch_if.sv
// ============================================================================
// Module   : ifu_prefetch_if
// Purpose  : Decode-side handshake and redirect bundle for ifu_prefetch.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ifu_prefetch_if #(
   parameter int QDEPTH = 4
);
   localparam int QW = $clog2(QDEPTH);

   logic          npc_sel;
   logic          zero;
   logic          jctl;
   logic          jr_sel;
   logic [31:0]   jr_target;
   logic          out_ready;
   logic          out_valid;
   logic [31:0]   insout;
   logic [31:0]   pc_out;
   logic [QW:0]   q_count;

   // master = decode stage, slave = fetch unit
   modport master (
      output npc_sel, zero, jctl, jr_sel, jr_target, out_ready,
      input  out_valid, insout, pc_out, q_count
   );

   modport slave (
      input  npc_sel, zero, jctl, jr_sel, jr_target, out_ready,
      output out_valid, insout, pc_out, q_count
   );
endinterface

`default_nettype wire

// File: rtl/ifu_prefetch.sv
// ============================================================================
// Module   : ifu_prefetch
// Purpose  : Sequential instruction fetch into a prefetch FIFO; redirects flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ifu_prefetch #(
   parameter int          IM_DEPTH = 1024,
   parameter int          QDEPTH   = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic            clk,
   input  logic            reset,
   ifu_prefetch_if.slave   bus
);
   localparam int          AW   = $clog2(IM_DEPTH);
   localparam int          QW   = $clog2(QDEPTH);
   localparam logic [QW:0] FULL = (QW+1)'(QDEPTH);

   reg   [31:0]   im [0:IM_DEPTH-1];

   logic [31:0]   fetch_pc;
   logic [31:0]   q_pc  [QDEPTH];
   logic [31:0]   q_ins [QDEPTH];
   logic [QW-1:0] wr_ptr;
   logic [QW-1:0] rd_ptr;
   logic [QW:0]   count;

   logic [31:0]   head_pc;
   logic [31:0]   head_ins;
   logic [31:0]   pc_plus4;
   logic [31:0]   target;
   logic          fire;
   logic          redirect;
   logic          push;

   assign head_pc  = q_pc[rd_ptr];
   assign head_ins = q_ins[rd_ptr];
   assign pc_plus4 = head_pc + 32'd4;
   assign fire     = (count != '0) && bus.out_ready;

   // Redirect decision is made against the entry being consumed this cycle
   always_comb begin
      redirect = 1'b0;
      target   = '0;
      if (fire) begin
         if (bus.jr_sel) begin
            redirect = 1'b1;
            target   = bus.jr_target;
         end else if (bus.jctl) begin
            redirect = 1'b1;
            target   = {pc_plus4[31:28], head_ins[25:0], 2'b00};
         end else if (bus.npc_sel && bus.zero) begin
            redirect = 1'b1;
            target   = pc_plus4 + {{14{head_ins[15]}}, head_ins[15:0], 2'b00};
         end
      end
   end

   assign push = ((count != FULL) || fire) && !redirect;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else if (redirect) begin
         fetch_pc <= target;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 1'b1;
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !fire) begin
            count <= count + 1'b1;
         end else if (fire && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // Queue storage carries no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]  <= fetch_pc;
         q_ins[wr_ptr] <= im[fetch_pc[AW+1:2]];
      end
   end

   assign bus.out_valid = (count != '0);
   assign bus.insout    = head_ins;
   assign bus.pc_out    = head_pc;
   assign bus.q_count   = count;
endmodule

`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
// ============================================================================
// Module   : tb_ifu_prefetch
// Purpose  : Directed and randomized checks of ifu_prefetch against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ifu_prefetch;
   localparam int          IM_DEPTH = 1024;
   localparam int          QDEPTH   = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   logic        clk;
   logic        reset;
   ent_t        mq[$];
   logic [31:0] mpc;
   logic [31:0] mem [IM_DEPTH];
   int          n_cmp  = 0;
   int          n_fail = 0;

   ifu_prefetch_if #(.QDEPTH(QDEPTH)) bus ();

   ifu_prefetch #(
      .IM_DEPTH (IM_DEPTH),
      .QDEPTH   (QDEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic load(input int idx, input logic [31:0] v);
      mem[idx]    = v;
      dut.im[idx] = v;
   endtask

   // Reference: a list of fetched (pc, word) pairs plus the next fetch address
   task automatic model_tick();
      logic [31:0] p4, tgt;
      bit          fire, redir, can_push;
      ent_t        h, e;
      int          off;
      if (reset) begin
         mq.delete();
         mpc = RESET_PC;
         return;
      end
      fire  = (mq.size() > 0) && (bus.out_ready === 1'b1);
      redir = 0;
      tgt   = '0;
      if (fire) begin
         h  = mq[0];
         p4 = h.pc + 32'd4;
         if (bus.jr_sel) begin
            redir = 1; tgt = bus.jr_target;
         end else if (bus.jctl) begin
            redir = 1; tgt = (p4 & 32'hF000_0000) | ((h.ins & 32'h03FF_FFFF) * 4);
         end else if (bus.npc_sel && bus.zero) begin
            off   = int'($signed(h.ins[15:0]));
            redir = 1; tgt = p4 + 32'(off * 4);
         end
      end
      if (redir) begin
         mq.delete();
         mpc = tgt;
         return;
      end
      can_push = (mq.size() < QDEPTH) || fire;
      if (fire) void'(mq.pop_front());
      if (can_push) begin
         e.pc  = mpc;
         e.ins = mem[(mpc / 4) % IM_DEPTH];
         mq.push_back(e);
         mpc = mpc + 32'd4;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic clear_ctl();
      bus.npc_sel = 0; bus.zero = 0; bus.jctl = 0; bus.jr_sel = 0; bus.jr_target = '0;
   endtask

   task automatic do_reset();
      reset = 1; clear_ctl(); step(); step(); reset = 0;
   endtask

   task automatic advance_to(input logic [31:0] pc, output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid === 1'b1 && bus.pc_out === pc) begin
            ok = 1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      bus.out_ready = 1; reset = 1; clear_ctl();
      step(); step();
      n_cmp++; if (bus.q_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.q_count); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (dut.fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", dut.fetch_pc, RESET_PC); end
      reset = 0;
      step();
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", bus.out_valid); end
      n_cmp++; if (bus.pc_out !== RESET_PC) begin n_fail++; $display("FAIL first_pc: got %h want %h", bus.pc_out, RESET_PC); end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 8; i++) load(i, 32'hC0DE_0100 + 32'(i));
      bus.out_ready = 1;
      do_reset();
      step();
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, bus.out_valid); end
         n_cmp++; if (bus.pc_out !== RESET_PC + 32'(4*i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc_out, RESET_PC + 32'(4*i)); end
         n_cmp++; if (bus.insout !== 32'hC0DE_0100 + 32'(i)) begin n_fail++; $display("FAIL seq_ins[%0d]: got %h want %h", i, bus.insout, 32'hC0DE_0100 + 32'(i)); end
         step();
      end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 0;
      do_reset();
      repeat (10) step();
      n_cmp++; if (bus.q_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", bus.q_count); end
      n_cmp++; if (dut.fetch_pc !== 32'h0000_3010) begin n_fail++; $display("FAIL bp_fetch_pc: got %h want 00003010", dut.fetch_pc); end
      bus.out_ready = 1;
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (bus.pc_out !== RESET_PC + 32'(4*i)) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h want %h", i, bus.pc_out, RESET_PC + 32'(4*i)); end
         n_cmp++; if (bus.insout !== 32'hC0DE_0100 + 32'(i)) begin n_fail++; $display("FAIL bp_ins[%0d]: got %h want %h", i, bus.insout, 32'hC0DE_0100 + 32'(i)); end
         step();
      end
   endtask

   task automatic test_branch();
      bit ok;
      load(2, 32'h1000_0003);
      bus.out_ready = 1;
      do_reset();
      advance_to(32'h0000_3008, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL br_reach: head 3008 not seen, got %h", bus.pc_out); end
      bus.npc_sel = 1; bus.zero = 1;
      step(); clear_ctl();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble: got %b want 0", bus.out_valid); end
      n_cmp++; if (dut.fetch_pc !== 32'h0000_3018) begin n_fail++; $display("FAIL br_fetch_pc: got %h want 00003018", dut.fetch_pc); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h0000_3018) begin n_fail++; $display("FAIL br_target: got v=%b pc=%h want v=1 pc=00003018", bus.out_valid, bus.pc_out); end
      do_reset();
      advance_to(32'h0000_3008, ok);
      bus.npc_sel = 1; bus.zero = 0;
      step(); clear_ctl();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h0000_300C) begin n_fail++; $display("FAIL br_not_taken: got v=%b pc=%h want v=1 pc=0000300c", bus.out_valid, bus.pc_out); end
   endtask

   task automatic test_jump_priority();
      bit ok;
      load(1, 32'h0800_0C10);
      bus.out_ready = 1;
      do_reset();
      advance_to(32'h0000_3004, ok);
      bus.jctl = 1;
      step(); clear_ctl();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL j_bubble: got %b want 0", bus.out_valid); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h0000_3040) begin n_fail++; $display("FAIL j_target: got v=%b pc=%h want v=1 pc=00003040", bus.out_valid, bus.pc_out); end
      bus.jr_sel = 1; bus.jctl = 1; bus.npc_sel = 1; bus.zero = 1; bus.jr_target = 32'h0000_3100;
      step(); clear_ctl();
      step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h0000_3100) begin n_fail++; $display("FAIL jr_priority: got v=%b pc=%h want v=1 pc=00003100", bus.out_valid, bus.pc_out); end
   endtask

   task automatic test_wrap();
      bit ok;
      load(IM_DEPTH-1, 32'hDEAD_1023);
      load(0, 32'hBEEF_0000);
      bus.out_ready = 1;
      do_reset();
      advance_to(RESET_PC, ok);
      bus.jr_sel = 1; bus.jr_target = 32'h0000_3FFC;
      step(); clear_ctl();
      step();
      n_cmp++; if (bus.pc_out !== 32'h0000_3FFC || bus.insout !== 32'hDEAD_1023) begin n_fail++; $display("FAIL wrap_top: got pc=%h ins=%h want pc=00003ffc ins=dead1023", bus.pc_out, bus.insout); end
      step();
      n_cmp++; if (bus.pc_out !== 32'h0000_4000 || bus.insout !== 32'hBEEF_0000) begin n_fail++; $display("FAIL wrap_zero: got pc=%h ins=%h want pc=00004000 ins=beef0000", bus.pc_out, bus.insout); end
      load(3, 32'h1000_FFFF);
      do_reset();
      advance_to(32'h0000_300C, ok);
      bus.npc_sel = 1; bus.zero = 1;
      step(); clear_ctl();
      step();
      n_cmp++; if (bus.pc_out !== 32'h0000_300C || bus.insout !== 32'h1000_FFFF) begin n_fail++; $display("FAIL br_self: got pc=%h ins=%h want pc=0000300c ins=1000ffff", bus.pc_out, bus.insout); end
   endtask

   task automatic test_reset_midstream();
      bus.out_ready = 0;
      do_reset();
      repeat (6) step();
      n_cmp++; if (bus.q_count !== 3'd4) begin n_fail++; $display("FAIL mid_full: got %0d want 4", bus.q_count); end
      bus.out_ready = 1; bus.jr_sel = 1; bus.jr_target = 32'h0000_5000; reset = 1;
      step();
      reset = 0; clear_ctl();
      n_cmp++; if (bus.q_count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", bus.q_count); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
      n_cmp++; if (dut.fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL mid_fetch_pc: got %h want %h", dut.fetch_pc, RESET_PC); end
      step();
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.pc_out !== RESET_PC) begin n_fail++; $display("FAIL mid_restart: got v=%b pc=%h want v=1 pc=%h", bus.out_valid, bus.pc_out, RESET_PC); end
   endtask

   task automatic test_random();
      for (int i = 0; i < IM_DEPTH; i++) load(i, $urandom);
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.out_ready = ($urandom_range(0, 9) < 7);
         bus.jr_sel    = ($urandom_range(0, 15) == 0);
         bus.jctl      = ($urandom_range(0, 11) == 0);
         bus.npc_sel   = ($urandom_range(0, 5) == 0);
         bus.zero      = $urandom_range(0, 1) == 1;
         bus.jr_target = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : (32'h0000_3000 + 32'($urandom_range(0, 1023) * 4));
         reset         = ($urandom_range(0, 99) == 0);
         step();
         n_cmp++; if (bus.q_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", c, bus.q_count, mq.size()); end
         n_cmp++; if (bus.out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", c, bus.out_valid, mq.size() != 0); end
         n_cmp++; if (dut.fetch_pc !== mpc) begin n_fail++; $display("FAIL rnd_fetch_pc @%0d: got %h want %h", c, dut.fetch_pc, mpc); end
         if (mq.size() != 0) begin
            n_cmp++; if (bus.pc_out !== mq[0].pc || bus.insout !== mq[0].ins) begin n_fail++; $display("FAIL rnd_head @%0d: got pc=%h ins=%h want pc=%h ins=%h", c, bus.pc_out, bus.insout, mq[0].pc, mq[0].ins); end
         end
      end
      reset = 0;
      clear_ctl();
   endtask

   initial begin
      clk = 0;
      reset = 1;
      bus.out_ready = 0;
      clear_ctl();
      for (int i = 0; i < IM_DEPTH; i++) load(i, $urandom);
      test_reset();
      test_sequential();
      test_backpressure();
      test_branch();
      test_jump_priority();
      test_wrap();
      test_reset_midstream();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
